// File: rtl/apb_master_bridge.sv
// rtl/apb_master_bridge.sv - APB initiator that turns peripheral-mapped lw/sw into one APB transfer
// Stalls the core with stop while the SETUP/ACCESS handshake runs, then releases it in DONE.
module apb_master_bridge #(
   parameter logic [3:0]  PERIPH_NIBBLE = 4'h4,
   parameter int          TIMEOUT       = 16,
   parameter logic [31:0] ERR_DATA      = 32'hDEAD_BEEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] Instr,
   input  logic [31:0] Reg1_out,
   input  logic [31:0] Reg2_out,
   output logic        cancel_data_memory,
   output logic        stop,
   output logic [31:0] rdata,
   output logic        rd_valid,
   output logic        err,
   output logic [31:0] PADDR,
   output logic [31:0] PWDATA,
   output logic        PWRITE,
   output logic [3:0]  PSEL,
   output logic        PENABLE,
   input  logic [31:0] PRDATA,
   input  logic        PREADY,
   input  logic        PSLVERR
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_DONE} state_t;

   state_t             r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic [31:0]        r_paddr;
   logic [31:0]        r_pwdata;
   logic               r_pwrite;
   logic [3:0]         r_psel;
   logic               r_penable;
   logic [31:0]        r_rdata;
   logic               r_rd_valid;
   logic               r_err;

   logic               w_is_lw;
   logic               w_is_sw;
   logic [31:0]        w_imm;
   logic [31:0]        w_addr;
   logic               w_periph_req;
   logic               w_unused_rs1;

   assign w_is_lw = (Instr[6:0] == 7'b0000011) && (Instr[14:12] == 3'b010);
   assign w_is_sw = (Instr[6:0] == 7'b0100011) && (Instr[14:12] == 3'b010);
   assign w_imm   = w_is_sw ? {{20{Instr[31]}}, Instr[31:25], Instr[11:7]}
                            : {{20{Instr[31]}}, Instr[31:20]};
   assign w_addr  = Reg1_out + w_imm;
   assign w_periph_req = (w_is_lw || w_is_sw) && (w_addr[31:28] == PERIPH_NIBBLE);
   // rs1 arrives already resolved through Reg1_out
   assign w_unused_rs1 = ^Instr[19:15];

   assign cancel_data_memory = !rst && w_periph_req;
   assign stop               = !rst && w_periph_req && (r_state != S_DONE);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_paddr    <= '0;
         r_pwdata   <= '0;
         r_pwrite   <= 1'b0;
         r_psel     <= 4'b0;
         r_penable  <= 1'b0;
         r_rdata    <= '0;
         r_rd_valid <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_periph_req) begin
                  r_state  <= S_SETUP;
                  r_paddr  <= w_addr;
                  r_pwdata <= Reg2_out;
                  r_pwrite <= w_is_sw;
                  r_psel   <= 4'b0001 << w_addr[13:12];
               end
            end
            S_SETUP: begin
               r_state   <= S_ACCESS;
               r_penable <= 1'b1;
            end
            S_ACCESS: begin
               if (PREADY) begin
                  r_state    <= S_DONE;
                  r_psel     <= 4'b0;
                  r_penable  <= 1'b0;
                  r_rd_valid <= !r_pwrite;
                  r_err      <= PSLVERR;
                  if (!r_pwrite) begin
                     r_rdata <= PSLVERR ? ERR_DATA : PRDATA;
                  end
               end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                  // slave never answered: abort and report as an error
                  r_state    <= S_DONE;
                  r_psel     <= 4'b0;
                  r_penable  <= 1'b0;
                  r_rd_valid <= !r_pwrite;
                  r_err      <= 1'b1;
                  if (!r_pwrite) begin
                     r_rdata <= ERR_DATA;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_DONE: begin
               r_state    <= S_IDLE;
               r_rd_valid <= 1'b0;
               r_err      <= 1'b0;
               r_cnt      <= '0;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign PADDR    = r_paddr;
   assign PWDATA   = r_pwdata;
   assign PWRITE   = r_pwrite;
   assign PSEL     = r_psel;
   assign PENABLE  = r_penable;
   assign rdata    = r_rdata;
   assign rd_valid = r_rd_valid;
   assign err      = r_err;

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb/tb_apb_master_bridge.sv - directed vector bench for apb_master_bridge
module tb_apb_master_bridge;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] Instr, Reg1_out, Reg2_out;
   logic        cancel_data_memory, stop;
   logic [31:0] rdata;
   logic        rd_valid, err;
   logic [31:0] PADDR, PWDATA;
   logic        PWRITE;
   logic [3:0]  PSEL;
   logic        PENABLE;
   logic [31:0] PRDATA;
   logic        PREADY, PSLVERR;

   int n_cmp  = 0;
   int n_fail = 0;

   localparam logic [31:0] NOP = 32'h0000_0013;

   always #5 clk = ~clk;

   apb_master_bridge dut (
      .clk(clk), .rst(rst), .Instr(Instr), .Reg1_out(Reg1_out), .Reg2_out(Reg2_out),
      .cancel_data_memory(cancel_data_memory), .stop(stop), .rdata(rdata),
      .rd_valid(rd_valid), .err(err), .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE),
      .PSEL(PSEL), .PENABLE(PENABLE), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
   );

   typedef struct {
      logic [31:0] instr;
      logic [31:0] reg1;
      logic [31:0] reg2;
      logic [31:0] prdata;
      logic        pslverr;
      logic        exp_periph;
      logic [31:0] exp_paddr;
      logic [3:0]  exp_psel;
      logic        exp_pwrite;
      logic [31:0] exp_rdata;
      logic        exp_rd_valid;
      logic        exp_err;
   } vec_t;

   vec_t vecs[10];

   function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [2:0] f3,
                                         input logic [6:0] op);
      return {imm, 5'd1, f3, 5'd5, op};
   endfunction

   function automatic logic [31:0] enc_sw(input logic [11:0] imm);
      return {imm[11:5], 5'd2, 5'd1, 3'b010, imm[4:0], 7'b0100011};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int sc, acc;
      bit done;

      vecs[0] = '{enc_i(12'h004, 3'b010, 7'b0000011), 32'h4000_1000, 32'h0, 32'h1234_5678, 1'b0,
                  1'b1, 32'h4000_1004, 4'b0010, 1'b0, 32'h1234_5678, 1'b1, 1'b0};
      vecs[1] = '{enc_i(12'h040, 3'b010, 7'b0000011), 32'h0000_0000, 32'h0, 32'h0, 1'b0,
                  1'b0, 32'h0, 4'b0, 1'b0, 32'h0, 1'b0, 1'b0};
      vecs[2] = '{enc_sw(12'h008), 32'h4000_2000, 32'hCAFE_F00D, 32'h0, 1'b0,
                  1'b1, 32'h4000_2008, 4'b0100, 1'b1, 32'h0, 1'b0, 1'b0};
      vecs[3] = '{enc_i(12'hFFC, 3'b010, 7'b0000011), 32'h4000_0004, 32'h0, 32'h1111_1111, 1'b1,
                  1'b1, 32'h4000_0000, 4'b0001, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b1};
      vecs[4] = '{enc_i(12'hFFF, 3'b010, 7'b0000011), 32'h4000_0000, 32'h0, 32'h0, 1'b0,
                  1'b0, 32'h0, 4'b0, 1'b0, 32'h0, 1'b0, 1'b0};
      vecs[5] = '{enc_i(12'h008, 3'b010, 7'b0000011), 32'h3FFF_FFF8, 32'h0, 32'h0BAD_CAFE, 1'b0,
                  1'b1, 32'h4000_0000, 4'b0001, 1'b0, 32'h0BAD_CAFE, 1'b1, 1'b0};
      vecs[6] = '{enc_i(12'h000, 3'b000, 7'b0000011), 32'h4000_1000, 32'h0, 32'h0, 1'b0,
                  1'b0, 32'h0, 4'b0, 1'b0, 32'h0, 1'b0, 1'b0};
      vecs[7] = '{enc_i(12'h000, 3'b010, 7'b0010011), 32'h4000_0000, 32'h0, 32'h0, 1'b0,
                  1'b0, 32'h0, 4'b0, 1'b0, 32'h0, 1'b0, 1'b0};
      vecs[8] = '{enc_i(12'h000, 3'b010, 7'b0000011), 32'h5000_0000, 32'h0, 32'h0, 1'b0,
                  1'b0, 32'h0, 4'b0, 1'b0, 32'h0, 1'b0, 1'b0};
      vecs[9] = '{enc_sw(12'h7FF), 32'h4000_2801, 32'h0000_0055, 32'h0, 1'b1,
                  1'b1, 32'h4000_3000, 4'b1000, 1'b1, 32'h0, 1'b0, 1'b1};

      rst = 1'b1; Instr = NOP; Reg1_out = '0; Reg2_out = '0;
      PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
      tick(); tick();
      rst = 1'b0;
      #1;
      chk("reset_psel", 32'(PSEL), 32'h0);
      chk("reset_penable", 32'(PENABLE), 32'h0);
      chk("reset_paddr", PADDR, 32'h0);
      chk("reset_rdata", rdata, 32'h0);
      chk("reset_rd_valid", 32'(rd_valid), 32'h0);
      chk("reset_err", 32'(err), 32'h0);
      chk("reset_stop", 32'(stop), 32'h0);

      // zero-wait transfers and non-peripheral decodes, back to back
      for (int i = 0; i < 10; i++) begin
         Instr = vecs[i].instr; Reg1_out = vecs[i].reg1; Reg2_out = vecs[i].reg2;
         PRDATA = vecs[i].prdata; PSLVERR = vecs[i].pslverr; PREADY = 1'b1;
         #1;
         chk($sformatf("v%0d_cancel", i), 32'(cancel_data_memory), 32'(vecs[i].exp_periph));
         chk($sformatf("v%0d_stop_t0", i), 32'(stop), 32'(vecs[i].exp_periph));
         chk($sformatf("v%0d_rdv_idle", i), 32'(rd_valid), 32'h0);
         if (vecs[i].exp_periph) begin
            tick();
            chk($sformatf("v%0d_psel", i), 32'(PSEL), 32'(vecs[i].exp_psel));
            chk($sformatf("v%0d_paddr", i), PADDR, vecs[i].exp_paddr);
            chk($sformatf("v%0d_pwrite", i), 32'(PWRITE), 32'(vecs[i].exp_pwrite));
            chk($sformatf("v%0d_penable_setup", i), 32'(PENABLE), 32'h0);
            if (vecs[i].exp_pwrite) chk($sformatf("v%0d_pwdata", i), PWDATA, vecs[i].reg2);
            tick();
            chk($sformatf("v%0d_penable_access", i), 32'(PENABLE), 32'h1);
            chk($sformatf("v%0d_stop_access", i), 32'(stop), 32'h1);
            tick();
            chk($sformatf("v%0d_stop_done", i), 32'(stop), 32'h0);
            chk($sformatf("v%0d_psel_done", i), 32'(PSEL), 32'h0);
            chk($sformatf("v%0d_rd_valid", i), 32'(rd_valid), 32'(vecs[i].exp_rd_valid));
            chk($sformatf("v%0d_err", i), 32'(err), 32'(vecs[i].exp_err));
            if (!vecs[i].exp_pwrite) chk($sformatf("v%0d_rdata", i), rdata, vecs[i].exp_rdata);
            tick();
         end else begin
            tick();
            chk($sformatf("v%0d_psel_idle", i), 32'(PSEL), 32'h0);
            chk($sformatf("v%0d_stop_idle", i), 32'(stop), 32'h0);
         end
      end

      // write with two wait states
      Instr = enc_sw(12'hFF8); Reg1_out = 32'h4000_3010; Reg2_out = 32'hA5A5_0001;
      PREADY = 1'b0; PSLVERR = 1'b0;
      #1;
      sc = stop ? 1 : 0; acc = 0; done = 1'b0;
      for (int c = 0; c < 20 && !done; c++) begin
         tick();
         if (PENABLE) acc++;
         PREADY = (acc >= 3);
         if (PSEL != 4'b0 && !PENABLE) begin
            chk("wr_paddr", PADDR, 32'h4000_3008);
            chk("wr_pwdata", PWDATA, 32'hA5A5_0001);
            chk("wr_psel", 32'(PSEL), 32'h8);
         end
         if (stop) sc++;
         else done = 1'b1;
      end
      chk("wr_done_reached", 32'(done), 32'h1);
      chk("wr_stop_cycles", sc, 5);
      chk("wr_rd_valid", 32'(rd_valid), 32'h0);
      chk("wr_err", 32'(err), 32'h0);
      tick();
      Instr = NOP;

      // timeout on a read
      Instr = enc_i(12'h004, 3'b010, 7'b0000011); Reg1_out = 32'h4000_1000;
      PREADY = 1'b0; PRDATA = 32'h7777_7777;
      acc = 0; done = 1'b0;
      for (int c = 0; c < 40 && !done; c++) begin
         tick();
         if (PENABLE) acc++;
         if (!stop) done = 1'b1;
      end
      chk("to_done_reached", 32'(done), 32'h1);
      chk("to_access_cycles", acc, 16);
      chk("to_err", 32'(err), 32'h1);
      chk("to_rdata", rdata, 32'hDEAD_BEEF);
      chk("to_psel", 32'(PSEL), 32'h0);
      tick();
      Instr = NOP;
      #1;
      chk("to_err_clear", 32'(err), 32'h0);
      chk("to_stop_released", 32'(stop), 32'h0);

      // reset while a read is waiting in ACCESS
      Instr = enc_i(12'h004, 3'b010, 7'b0000011); Reg1_out = 32'h4000_1000; PREADY = 1'b0;
      tick(); tick(); tick();
      chk("rs_in_access", 32'(PENABLE), 32'h1);
      rst = 1'b1;
      #1;
      chk("rs_stop_forced", 32'(stop), 32'h0);
      chk("rs_cancel_forced", 32'(cancel_data_memory), 32'h0);
      tick();
      rst = 1'b0; Instr = NOP;
      #1;
      chk("rs_psel", 32'(PSEL), 32'h0);
      chk("rs_penable", 32'(PENABLE), 32'h0);
      chk("rs_paddr", PADDR, 32'h0);
      chk("rs_pwrite", 32'(PWRITE), 32'h0);
      chk("rs_rdata", rdata, 32'h0);
      chk("rs_err", 32'(err), 32'h0);
      for (int c = 0; c < 3; c++) begin
         chk("rs_no_rd_valid", 32'(rd_valid), 32'h0);
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- Initiator-side bridge between the single-cycle RISC-V core and the APB peripheral bus.
- Decodes the core's current lw/sw instruction and computes its effective address.
- For peripheral-mapped addresses it asserts cancel_data_memory, holds the core with stop, and runs one APB transfer (SETUP then ACCESS, with wait states and a timeout).
- Returns read data with a one-cycle valid pulse, in the cycle the core is released.

Parameters:
- PERIPH_NIBBLE, 4'h4, value of addr[31:28] that selects the peripheral region.
- TIMEOUT, 16, maximum ACCESS cycles without PREADY before the transfer is aborted.
- ERR_DATA, 32'hDEAD_BEEF, value returned as rdata on an aborted or errored read.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- Instr  in  32  current instruction from the core.
- Reg1_out  in  32  rs1 value (address base).
- Reg2_out  in  32  rs2 value (store data).
- cancel_data_memory  out  1  combinational; suppresses the data-memory write.
- stop  out  1  combinational; freezes the PC.
- rdata  out  32  registered load result.
- rd_valid  out  1  registered; high only in the DONE cycle of a read.
- err  out  1  registered; high in the DONE cycle if PSLVERR or timeout.
- PADDR  out  32  APB address.
- PWDATA  out  32  APB write data.
- PWRITE  out  1  APB direction.
- PSEL  out  4  one-hot slave select.
- PENABLE  out  1  APB enable.
- PRDATA  in  32  APB read data.
- PREADY  in  1  APB ready.
- PSLVERR  in  1  APB slave error.

Behaviour:
- Clock and reset:
  - Single clock, clk.
  - rst is synchronous and active-high.
  - On a rst edge: state=IDLE; PADDR, PWDATA, rdata=0; PWRITE, PENABLE, rd_valid, err=0; PSEL=4'b0; timeout counter=0.
  - While rst=1, stop and cancel_data_memory are forced to 0.
- Decode (combinational):
  - lw: opcode 7'b0000011, funct3 3'b010. Address = Reg1_out + sign-extended Instr[31:20].
  - sw: opcode 7'b0100011, funct3 3'b010. Address = Reg1_out + sign-extended {Instr[31:25], Instr[11:7]}.
  - Address arithmetic is 32-bit and wraps with carry discarded.
  - periph_req = (lw|sw) && addr[31:28]==PERIPH_NIBBLE. Other widths/opcodes are never peripheral.
- cancel_data_memory = periph_req.
- stop = periph_req && state!=DONE.
- FSM states: IDLE, SETUP, ACCESS, DONE.
  - IDLE -> SETUP when periph_req. On this edge latch PADDR=addr, PWDATA=Reg2_out, PWRITE=sw, PSEL=onehot(addr[13:12]).
  - SETUP -> ACCESS unconditionally. PENABLE=1 on entry. PADDR, PWDATA, PWRITE, PSEL are held stable through ACCESS.
  - ACCESS, PREADY=1 -> DONE:
    - Clear PSEL and PENABLE.
    - If read, rdata = PSLVERR ? ERR_DATA : PRDATA.
    - rd_valid=~PWRITE; err=PSLVERR.
  - ACCESS, PREADY=0: increment the counter. When it reaches TIMEOUT-1 -> DONE with err=1, rdata=ERR_DATA if read, PSEL/PENABLE cleared.
  - DONE -> IDLE unconditionally. stop is 0 here, so the PC advances on this edge. rd_valid and err clear on exit. The counter clears.
- Back-to-back:
  - The instruction held during DONE is never re-issued.
  - A peripheral instruction that follows immediately is detected in the next IDLE cycle.
- Latency (zero-wait slave):
  - Detect cycle T0 (IDLE), SETUP at T1, ACCESS at T2, DONE at T3.
  - stop is high T0–T2 and low at T3.
  - Each PREADY wait state adds one cycle.
- PSEL and PENABLE are never high outside SETUP/ACCESS. PENABLE is never high without PSEL.
- Reset mid-transfer: the bus is released on that edge with no DONE cycle and no rd_valid.
- Non-peripheral lw/sw and all other instructions: stop=0, cancel_data_memory=0, no bus activity.

Test Plan:
- Zero-wait read:
  - Stimulus: Instr=lw x5,4(x1), Reg1_out=32'h4000_1000, PREADY=1, PRDATA=32'h1234_5678.
  - Response: PADDR=32'h4000_1004, PSEL=4'b0010; stop high 3 cycles; DONE cycle rdata=32'h1234_5678 and rd_valid=1.
- Write with 2 wait states:
  - Stimulus: sw x2,-8(x1), Reg1_out=32'h4000_3010, Reg2_out=32'hA5A5_0001.
  - Response: PADDR=32'h4000_3008, PWDATA=32'hA5A5_0001, PSEL=4'b1000; stop high 5 cycles; rd_valid=0.
- Non-peripheral:
  - Stimulus: lw with address 32'h0000_0040.
  - Response: stop=0, cancel_data_memory=0, PSEL=0 throughout.
- PSLVERR read:
  - Stimulus: slave returns PREADY=1, PSLVERR=1.
  - Response: err=1, rdata=32'hDEAD_BEEF, rd_valid=1 for one cycle.
- Timeout:
  - Stimulus: PREADY held 0.
  - Response: DONE after TIMEOUT ACCESS cycles with err=1; PSEL=0 afterwards; core released.
- Reset in ACCESS:
  - Stimulus: rst=1 for one edge during a waited read.
  - Response: all outputs 0 next cycle, state IDLE, no rd_valid pulse.
